// File: rtl/nios2_mult_iter_cell.sv
// Iterative signed/unsigned DATA_W x DATA_W multiplier built around one CHUNK_W partial-product cell.
// Optional multiply-accumulate is enabled by defining MULT_ITER_ACC_EN (adds the acc_en input).
module nios2_mult_iter_cell #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned CHUNK_W = 16
) (
  input  logic              clk,
  input  logic              reset,
`ifdef MULT_ITER_ACC_EN
  input  logic              acc_en,
`endif
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  input  logic              src1_signed,
  input  logic              src2_signed,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result_lo,
  output logic [DATA_W-1:0] result_hi
);

  // DATA_W must be an integer multiple of CHUNK_W.
  localparam int unsigned N     = DATA_W / CHUNK_W;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned ACC_W = 2 * DATA_W;
  localparam int unsigned PP_W  = 2 * CHUNK_W + 2;
  localparam logic [IDX_W-1:0] IdxMax = IDX_W'(N - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e            r_state;
  logic [IDX_W-1:0]  r_i;
  logic [IDX_W-1:0]  r_j;
  logic [DATA_W-1:0] r_src1;
  logic [DATA_W-1:0] r_src2;
  logic              r_s1;
  logic              r_s2;
  logic [ACC_W-1:0]  r_acc;

  logic [CHUNK_W-1:0]      w_a_chunk;
  logic [CHUNK_W-1:0]      w_b_chunk;
  logic signed [CHUNK_W:0] w_a_ext;
  logic signed [CHUNK_W:0] w_b_ext;
  logic signed [PP_W-1:0]  w_pp;
  logic [ACC_W-1:0]        w_pp_ext;
  logic [ACC_W-1:0]        w_pp_sh;
  logic [31:0]             w_shamt;
  logic                    w_last;
  logic                    w_keep_acc;

`ifdef MULT_ITER_ACC_EN
  assign w_keep_acc = acc_en;
`else
  assign w_keep_acc = 1'b0;
`endif

  // Partial product k = i*N + j; j walks the src2 chunks fastest.
  always_comb begin
    w_a_chunk = CHUNK_W'(r_src1 >> (32'(r_i) * CHUNK_W));
    w_b_chunk = CHUNK_W'(r_src2 >> (32'(r_j) * CHUNK_W));
    // Only the top chunk of a signed operand carries the sign.
    w_a_ext   = {r_s1 & (r_i == IdxMax) & w_a_chunk[CHUNK_W-1], w_a_chunk};
    w_b_ext   = {r_s2 & (r_j == IdxMax) & w_b_chunk[CHUNK_W-1], w_b_chunk};
    w_pp      = PP_W'(w_a_ext) * PP_W'(w_b_ext);
    w_pp_ext  = ACC_W'(w_pp);
    w_shamt   = (32'(r_i) + 32'(r_j)) * CHUNK_W;
    w_pp_sh   = w_pp_ext << w_shamt;
    w_last    = (r_i == IdxMax) && (r_j == IdxMax);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
      r_i     <= '0;
      r_j     <= '0;
      r_src1  <= '0;
      r_src2  <= '0;
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_acc   <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_src1  <= src1;
            r_src2  <= src2;
            r_s1    <= src1_signed;
            r_s2    <= src2_signed;
            r_acc   <= w_keep_acc ? r_acc : '0;
            r_i     <= '0;
            r_j     <= '0;
            r_state <= StCalc;
          end
        end
        StCalc: begin
          r_acc <= r_acc + w_pp_sh;
          if (w_last) begin
            r_i     <= '0;
            r_j     <= '0;
            r_state <= StDone;
          end else if (r_j == IdxMax) begin
            r_j <= '0;
            r_i <= r_i + 1'b1;
          end else begin
            r_j <= r_j + 1'b1;
          end
        end
        StDone: begin
          if (out_ready) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign in_ready  = (r_state == StIdle);
  assign out_valid = (r_state == StDone);
  assign result_lo = r_acc[DATA_W-1:0];
  assign result_hi = r_acc[ACC_W-1:DATA_W];

endmodule

// File: tb/tb_nios2_mult_iter_cell.sv
// Directed bench for nios2_mult_iter_cell: latency, signedness, backpressure, reset abort, MAC.
module tb_nios2_mult_iter_cell;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        src1_signed;
  logic        src2_signed;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result_lo;
  logic [31:0] result_hi;
`ifdef MULT_ITER_ACC_EN
  logic        acc_en;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nios2_mult_iter_cell #(
    .DATA_W (32),
    .CHUNK_W(16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
`ifdef MULT_ITER_ACC_EN
    .acc_en     (acc_en),
`endif
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .src1       (src1),
    .src2       (src2),
    .src1_signed(src1_signed),
    .src2_signed(src2_signed),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result_lo  (result_lo),
    .result_hi  (result_hi)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents operands for one cycle; returns just after the accepting edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sa,
                       input logic sb);
    src1        = a;
    src2        = b;
    src1_signed = sa;
    src2_signed = sb;
    in_valid    = 1'b1;
    tick();
    in_valid    = 1'b0;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    src1 = 32'h5; src2 = 32'h7; src1_signed = 1'b0; src2_signed = 1'b0;
    tick();
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_vec++; if (result_lo !== 32'h0) begin n_err++; $display("FAIL rst_lo: got %h want 0", result_lo); end
    n_vec++; if (result_hi !== 32'h0) begin n_err++; $display("FAIL rst_hi: got %h want 0", result_hi); end
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_idle_hold: got %b want 1", in_ready); end
  endtask

  task automatic test_unsigned_max();
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c < 4) begin
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
          n_err++; $display("FAIL umax_early c=%0d: got ov=%b ir=%b want 0 0", c, out_valid, in_ready);
        end
      end else begin
        n_vec++;
        if (out_valid !== 1'b1) begin n_err++; $display("FAIL umax_latency: got %b want 1", out_valid); end
      end
    end
    n_vec++; if (result_hi !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL umax_hi: got %h want fffffffe", result_hi); end
    n_vec++; if (result_lo !== 32'h0000_0001) begin n_err++; $display("FAIL umax_lo: got %h want 00000001", result_lo); end
    release_result();
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL umax_release: got ir=%b ov=%b want 1 0", in_ready, out_valid);
    end
    n_vec++; if (result_hi !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL umax_retain: got %h want fffffffe", result_hi); end
  endtask

  task automatic test_signed_max();
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
    repeat (4) tick();
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL smax_valid: got %b want 1", out_valid); end
    n_vec++; if (result_hi !== 32'h0) begin n_err++; $display("FAIL smax_hi: got %h want 00000000", result_hi); end
    n_vec++; if (result_lo !== 32'h1) begin n_err++; $display("FAIL smax_lo: got %h want 00000001", result_lo); end
    release_result();
  endtask

  task automatic test_mixed_sign();
    issue(32'h8000_0000, 32'h0000_0002, 1'b1, 1'b0);
    // Operand changes after acceptance must not leak into the product.
    src1 = 32'h1234_5678; src2 = 32'h9ABC_DEF0; src1_signed = 1'b0; src2_signed = 1'b1;
    repeat (4) tick();
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL mixed_valid: got %b want 1", out_valid); end
    n_vec++; if (result_hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mixed_hi: got %h want ffffffff", result_hi); end
    n_vec++; if (result_lo !== 32'h0) begin n_err++; $display("FAIL mixed_lo: got %h want 00000000", result_lo); end
    release_result();
  endtask

  task automatic test_backpressure();
    issue(32'd7, 32'd9, 1'b0, 1'b0);
    repeat (4) tick();
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid: got %b want 1", out_valid); end
    for (int c = 0; c < 5; c++) begin
      src1 = 32'd100 + 32'(c); src2 = 32'd3; in_valid = 1'b1;
      tick();
      n_vec++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result_lo !== 32'h3F || result_hi !== 32'h0) begin
        n_err++;
        $display("FAIL bp_hold c=%0d: got ov=%b ir=%b hi=%h lo=%h want 1 0 0 3f", c, out_valid,
                 in_ready, result_hi, result_lo);
      end
    end
    in_valid = 1'b0;
    release_result();
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result_lo !== 32'h3F) begin
      n_err++; $display("FAIL bp_release: got ir=%b ov=%b lo=%h want 1 0 3f", in_ready, out_valid, result_lo);
    end
    tick();
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_no_second: got %b want 1", in_ready); end
  endtask

  task automatic test_reset_abort();
    issue(32'hFFFF_FFFF, 32'h0000_1234, 1'b0, 1'b0);
    tick();
    reset = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    tick();
    reset = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result_lo !== 32'h0 || result_hi !== 32'h0) begin
      n_err++; $display("FAIL abort_state: got ir=%b ov=%b hi=%h lo=%h want 1 0 0 0", in_ready,
                        out_valid, result_hi, result_lo);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL abort_pulse c=%0d: got %b want 0", c, out_valid); end
    end
    issue(32'd3, 32'd5, 1'b0, 1'b0);
    repeat (4) tick();
    n_vec++;
    if (out_valid !== 1'b1 || result_lo !== 32'hF || result_hi !== 32'h0) begin
      n_err++; $display("FAIL abort_next: got ov=%b hi=%h lo=%h want 1 0 f", out_valid, result_hi, result_lo);
    end
    release_result();
  endtask

  task automatic test_acc();
`ifdef MULT_ITER_ACC_EN
    localparam logic [31:0] ExpLo = 32'h2A;
    acc_en = 1'b0;
`else
    localparam logic [31:0] ExpLo = 32'h1E;
`endif
    issue(32'd3, 32'd4, 1'b0, 1'b0);
    repeat (4) tick();
    n_vec++; if (result_lo !== 32'hC) begin n_err++; $display("FAIL acc_first: got %h want c", result_lo); end
    release_result();
`ifdef MULT_ITER_ACC_EN
    acc_en = 1'b1;
`endif
    issue(32'd5, 32'd6, 1'b0, 1'b0);
`ifdef MULT_ITER_ACC_EN
    acc_en = 1'b0;
`endif
    repeat (4) tick();
    n_vec++; if (result_lo !== ExpLo) begin n_err++; $display("FAIL acc_lo: got %h want %h", result_lo, ExpLo); end
    n_vec++; if (result_hi !== 32'h0) begin n_err++; $display("FAIL acc_hi: got %h want 0", result_hi); end
    release_result();
  endtask

  initial begin
`ifdef MULT_ITER_ACC_EN
    acc_en = 1'b0;
`endif
    test_reset();
    test_unsigned_max();
    test_signed_max();
    test_mixed_sign();
    test_backpressure();
    test_reset_abort();
    test_acc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
